seg7_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display driven by TOP. It sequences the digit anodes one slot at a time and inserts a blanking gap between slots to suppress ghosting. It applies 8-level PWM brightness and optional leading-zero suppression. Displayed data is snapshotted once per frame, so a counter update can never tear a frame.

---
 rtl/seg7_pkg.sv | 11 +
 rtl/seg7_scan_controller_decoder.sv | 14 +
 rtl/seg7_scan_controller.sv | 72 +++++++
 tb/tb_seg7_scan_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions, hex-to-segment table and scan phase type
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {BLANK, ON, DIM} phase_t;
endpackage

// File: rtl/seg7_scan_controller_decoder.sv
// seg7_decoder: hex nibble plus dp to active-low segment byte with optional blanking
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb begin
    seg[SEG_DP] = ~dp;
    seg[SEG_G:SEG_A] = blank ? 7'h7F : ~SEG_TABLE[nibble];
  end
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: 4-digit multiplexed 7-segment scan with blanking gap, PWM and frame snapshot
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int BLANK_TICKS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic [2:0]  i_brightness,
  input  logic        i_blankLz,
  output logic [7:0]  o_LED,
  output logic [3:0]  o_digitSelect,
  output logic        o_frameStart
);
  localparam int SUB = (TICKS_PER_DIGIT - BLANK_TICKS) / 8;
  localparam int TW = $clog2(TICKS_PER_DIGIT);
  logic [TW-1:0] tick;
  logic [1:0] idx;
  logic [2:0] bri_q;
  logic [15:0] snap_digits;
  logic [3:0] snap_dp;
  logic snap_lz;
  logic [3:0] lz_blank;
  logic tick_last;
  logic frame_edge;
  logic [7:0] seg;
  phase_t phase;
  always_comb begin
    tick_last = tick == TW'(TICKS_PER_DIGIT - 1);
    frame_edge = tick == '0 && idx == '0;
    lz_blank[3] = snap_lz && snap_digits[15:12] == 4'h0;
    lz_blank[2] = lz_blank[3] && snap_digits[11:8] == 4'h0;
    lz_blank[1] = lz_blank[2] && snap_digits[7:4] == 4'h0;
    lz_blank[0] = 1'b0;
    phase = int'(tick) < BLANK_TICKS ? BLANK :
            int'(tick) < BLANK_TICKS + (int'(bri_q) + 1) * SUB ? ON : DIM;
  end
  seg7_decoder u_dec (
    .nibble(snap_digits[{idx, 2'b00} +: 4]),
    .dp(snap_dp[idx]),
    .blank(lz_blank[idx]),
    .seg(seg)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick <= '0;
      idx <= '0;
      bri_q <= '0;
      snap_digits <= '0;
      snap_dp <= '0;
      snap_lz <= 1'b0;
      o_LED <= 8'hFF;
      o_digitSelect <= 4'hF;
      o_frameStart <= 1'b0;
    end else begin
      tick <= tick_last ? '0 : tick + 1'b1;
      idx <= tick_last ? idx + 1'b1 : idx;
      if (tick == '0) bri_q <= i_brightness;
      if (frame_edge) begin
        snap_digits <= i_digits;
        snap_dp <= i_dp;
        snap_lz <= i_blankLz;
      end
      o_frameStart <= frame_edge;
      o_digitSelect <= phase == ON ? ~(4'b1 << idx) : 4'hF;
      o_LED <= phase == ON ? seg : 8'hFF;
    end
  end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: scoreboard bench checking per-slot anode, segments and on-time
module tb_seg7_scan_controller;
  timeunit 1ns;
  timeprecision 100ps;
  localparam int TPD = 24;
  localparam int BT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0] dp = '0;
  logic [2:0] bri = 3'd7;
  logic lz = 1'b0;
  logic [7:0] led;
  logic [3:0] sel;
  logic fs;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [3:0] sel;
    logic [7:0] led;
    int on;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int mon_c = -1;
  int on_cnt, first_on, bad_off;
  logic [3:0] sel_on;
  logic [7:0] led_on;
  seg7_scan_controller #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_digits(digits),
    .i_dp(dp),
    .i_brightness(bri),
    .i_blankLz(lz),
    .o_LED(led),
    .o_digitSelect(sel),
    .o_frameStart(fs)
  );
  always #1 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if ($countones(~sel) > 1) begin
      errors++;
      $display("FAIL onehot: select=%h, required at most one low bit", sel);
    end
    if (mon_c < 0 && fs === 1'b1 && q.size() >= 4) begin
      mon_c = 0;
      on_cnt = 0;
      first_on = -1;
      bad_off = 0;
      sel_on = 4'hF;
      led_on = 8'hFF;
    end
    if (mon_c >= 0) begin
      if (sel !== 4'hF) begin
        if (first_on < 0) first_on = mon_c % TPD;
        on_cnt++;
        sel_on = sel;
        led_on = led;
      end else if (led !== 8'hFF) bad_off++;
      if (mon_c % TPD == TPD - 1) begin
        e = q.pop_front();
        checks += 5;
        if (sel_on !== e.sel) begin errors++; $display("FAIL slot%0d select: got %h, required %h", mon_c / TPD, sel_on, e.sel); end
        if (led_on !== e.led) begin errors++; $display("FAIL slot%0d led: got %h, required %h", mon_c / TPD, led_on, e.led); end
        if (on_cnt != e.on) begin errors++; $display("FAIL slot%0d on_cycles: got %0d, required %0d", mon_c / TPD, on_cnt, e.on); end
        if (first_on != BT) begin errors++; $display("FAIL slot%0d on_start: got %0d, required %0d", mon_c / TPD, first_on, BT); end
        if (bad_off != 0) begin errors++; $display("FAIL slot%0d off_led: %0d off cycles with segments lit, required 0", mon_c / TPD, bad_off); end
        on_cnt = 0;
        first_on = -1;
        bad_off = 0;
        sel_on = 4'hF;
        led_on = 8'hFF;
      end
      mon_c = (mon_c == 4 * TPD - 1) ? -1 : mon_c + 1;
    end
  end
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #0.5;
    end
  endtask
  task automatic push4(input logic [7:0] l0, l1, l2, l3, input int on0, on);
    exp_t x;
    x = '{4'hE, l0, on0}; q.push_back(x);
    x = '{4'hD, l1, on}; q.push_back(x);
    x = '{4'hB, l2, on}; q.push_back(x);
    x = '{4'h7, l3, on}; q.push_back(x);
  endtask
  task automatic apply(input logic [15:0] d, input logic [3:0] p, input logic [2:0] b, input logic z);
    digits = d;
    dp = p;
    bri = b;
    lz = z;
    tick_n(1);
  endtask
  task automatic wait_mon(input int target);
    int n = 0;
    while (mon_c < target && n < 500) begin tick_n(1); n++; end
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || mon_c >= 0) && n < 500) begin tick_n(1); n++; end
    checks++;
    if (q.size() != 0 || mon_c >= 0) begin
      errors++;
      $display("FAIL drain: %0d slots unobserved after %0d cycles, required 0", q.size(), n);
      q.delete();
    end
  endtask
  task automatic test_reset();
    int pulses = 0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_n(1);
      checks += 3;
      if (led !== 8'hFF) begin errors++; $display("FAIL reset_led: got %h, required ff", led); end
      if (sel !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h, required f", sel); end
      if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b, required 0", fs); end
    end
    rst = 1'b0;
    tick_n(1);
    checks++;
    if (fs !== 1'b1) begin errors++; $display("FAIL first_frame: got %b, required 1", fs); end
    repeat (4 * TPD - 1) begin
      tick_n(1);
      if (fs === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL frame_gap: got %0d pulses, required 0", pulses); end
    tick_n(1);
    checks++;
    if (fs !== 1'b1) begin errors++; $display("FAIL frame_period: got %b, required 1", fs); end
  endtask
  task automatic test_digits();
    apply(16'h1234, 4'h0, 3'd7, 1'b0);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9, 16, 16);
    drain();
  endtask
  task automatic test_brightness();
    apply(16'h1234, 4'h0, 3'd0, 1'b0);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9, 2, 2);
    drain();
    apply(16'h1234, 4'h0, 3'd3, 1'b0);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 8);
    drain();
    apply(16'h1234, 4'h0, 3'd7, 1'b0);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9, 16, 2);
    wait_mon(11);
    bri = 3'd0;
    drain();
  endtask
  task automatic test_leading_zero();
    apply(16'h0070, 4'b0100, 3'd7, 1'b1);
    push4(8'hC0, 8'hF8, 8'h7F, 8'hFF, 16, 16);
    drain();
    apply(16'h0070, 4'b0100, 3'd7, 1'b0);
    push4(8'hC0, 8'hF8, 8'h40, 8'hC0, 16, 16);
    drain();
  endtask
  task automatic test_snapshot();
    apply(16'h1234, 4'h0, 3'd7, 1'b0);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9, 16, 16);
    wait_mon(60);
    digits = 16'h5678;
    drain();
    push4(8'h80, 8'hF8, 8'h82, 8'h92, 16, 16);
    drain();
  endtask
  task automatic test_reset_mid();
    int n = 0;
    apply(16'h1234, 4'h0, 3'd7, 1'b0);
    while (fs !== 1'b1 && n < 500) begin tick_n(1); n++; end
    tick_n(2 * TPD + 10);
    checks++;
    if (sel !== 4'hB) begin errors++; $display("FAIL mid_sel: got %h, required b", sel); end
    rst = 1'b1;
    tick_n(1);
    checks += 3;
    if (led !== 8'hFF) begin errors++; $display("FAIL abort_led: got %h, required ff", led); end
    if (sel !== 4'hF) begin errors++; $display("FAIL abort_sel: got %h, required f", sel); end
    if (fs !== 1'b0) begin errors++; $display("FAIL abort_fs: got %b, required 0", fs); end
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9, 16, 16);
    rst = 1'b0;
    tick_n(1);
    checks++;
    if (fs !== 1'b1) begin errors++; $display("FAIL restart_fs: got %b, required 1", fs); end
    drain();
  endtask
  initial begin
    test_reset();
    test_digits();
    test_brightness();
    test_leading_zero();
    test_snapshot();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
